// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared constants, write-FSM state encoding and the
//                bit-reversal scatter mapping for the 512-point reorder
//                buffer.
//                  LANES   - samples per beat
//                  NPOINT  - points per frame
//                  NBEAT   - beats per frame (NPOINT / LANES)
//                  BEAT_W  - log2(NBEAT)
//                  bitrev9 - 9-bit index reversal
//                  scatter_addr - memory address of input lane l, beat b
//  Revision    : 1.0  initial release
// ============================================================================
package fft_pkg;

    localparam int LANES  = 16;
    localparam int NPOINT = 512;
    localparam int NBEAT  = NPOINT / LANES;
    localparam int BEAT_W = $clog2(NBEAT);

    // Write-side frame sequencer states
    localparam int WR_STATE_W = 1;
    typedef logic [WR_STATE_W-1:0] wr_state_t;
    localparam wr_state_t W_HUNT = 1'b0;   // waiting for a start-of-frame beat
    localparam wr_state_t W_FILL = 1'b1;   // filling the current bank

    function automatic logic [8:0] bitrev9(input logic [8:0] idx);
        logic [8:0] rev;
        for (int i = 0; i < 9; i++) begin
            rev[i] = idx[8-i];
        end
        return rev;
    endfunction

    // Input point 16*b + l lands at its bit-reversed (natural-order) address
    function automatic logic [8:0] scatter_addr(input logic [3:0]        lane,
                                                input logic [BEAT_W-1:0] beat);
        return bitrev9({beat, lane});
    endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_ctrl
//  Description : Frame sequencer and ping-pong bank scheduler for the
//                512-point bit-reversal reorder buffer. Writes 16-lane
//                beats of each frame into one of two banks, drains full
//                banks in natural order under valid/ready. Control only,
//                no sample data.
//  Ports       : clk, rst                  - clock, sync active-high reset
//                in_valid, in_sof, in_ready - upstream beat handshake
//                wr_en, wr_bank, wr_beat    - reorder-memory write control
//                rd_en, rd_bank, rd_beat    - reorder-memory read control
//                out_valid, out_ready,
//                out_sof, out_eof           - downstream stream
//                frame_done, frames_out     - completion pulse and count
//                sof_err, err_clr           - sticky misaligned-SOF flag
//  Revision    : 1.0  initial release
// ============================================================================
module reorder_ctrl
    import fft_pkg::*;
#(
    parameter int NBEAT  = 32,
    parameter int BEAT_W = 5,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [BEAT_W-1:0] wr_beat,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [BEAT_W-1:0] rd_beat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eof,
    output logic              frame_done,
    output logic              sof_err,
    input  logic              err_clr,
    output logic [FCNT_W-1:0] frames_out
);

    localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(NBEAT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wr_state_t         r_wr_state;
    wr_state_t         w_wr_state_nxt;
    logic              r_wr_bank;
    logic [BEAT_W-1:0] r_wr_beat;
    logic [1:0]        r_bank_full;
    logic              r_sof_err;

    logic              r_rd_bank;
    logic [BEAT_W-1:0] r_rd_beat;
    logic              r_out_valid;
    logic              r_out_sof;
    logic              r_out_eof;
    logic [FCNT_W-1:0] r_frames_out;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_wr_en;
    logic              w_abort;
    logic              w_fill_last;
    logic              w_rd_en;
    logic              w_rd_last;
    logic              w_frame_done;
    logic [1:0]        w_bank_set;
    logic [1:0]        w_bank_clr;

    // ------------------------------------------------------------------
    // Write FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= W_HUNT;
        end else begin
            r_wr_state <= w_wr_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Write FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            W_HUNT: if (w_accept && in_sof) w_wr_state_nxt = W_FILL;
            W_FILL: if (w_fill_last)        w_wr_state_nxt = W_HUNT;
            default:                        w_wr_state_nxt = W_HUNT;
        endcase
    end

    // ------------------------------------------------------------------
    // Write FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready  = !rst && !r_bank_full[r_wr_bank];
        w_accept    = in_valid && w_in_ready;
        w_wr_en     = 1'b0;
        w_abort     = 1'b0;
        w_fill_last = 1'b0;
        case (r_wr_state)
            // Beats before the first SOF are accepted and dropped
            W_HUNT: w_wr_en = w_accept && in_sof;
            W_FILL: begin
                w_wr_en     = w_accept;
                // A new SOF mid-frame restarts the frame in the same bank
                w_abort     = w_accept && in_sof && (r_wr_beat != '0);
                w_fill_last = w_accept && !w_abort && (r_wr_beat == c_last_beat);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Write datapath: beat index, bank pointer, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_wr_beat <= '0;
            r_sof_err <= 1'b0;
        end else begin
            if (w_wr_en) begin
                if (w_fill_last) begin
                    r_wr_beat <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else if (w_abort) begin
                    // The restarting beat is written as beat 0
                    r_wr_beat <= BEAT_W'(1);
                end else begin
                    r_wr_beat <= r_wr_beat + 1'b1;
                end
            end
            // A new error wins over a simultaneous clear
            if (w_abort) begin
                r_sof_err <= 1'b1;
            end else if (err_clr) begin
                r_sof_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bank occupancy: filled by the writer, released by the reader.
    // The writer never targets a full bank, so set/clear of the same bank
    // cannot coincide; both banks may change in one cycle.
    // ------------------------------------------------------------------
    assign w_bank_set = {2{w_fill_last}}          & {r_wr_bank, ~r_wr_bank};
    assign w_bank_clr = {2{w_rd_en && w_rd_last}} & {r_rd_bank, ~r_rd_bank};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank_full <= 2'b00;
        end else begin
            r_bank_full <= (r_bank_full | w_bank_set) & ~w_bank_clr;
        end
    end

    // ------------------------------------------------------------------
    // Read side: issue a read whenever the output slot is free or being
    // emptied; output flags track the 1-cycle memory latency.
    // ------------------------------------------------------------------
    assign w_rd_en      = !rst && r_bank_full[r_rd_bank] && (!r_out_valid || out_ready);
    assign w_rd_last    = (r_rd_beat == c_last_beat);
    assign w_frame_done = !rst && r_out_valid && out_ready && r_out_eof;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_bank    <= 1'b0;
            r_rd_beat    <= '0;
            r_out_valid  <= 1'b0;
            r_out_sof    <= 1'b0;
            r_out_eof    <= 1'b0;
            r_frames_out <= '0;
        end else begin
            if (w_rd_en) begin
                r_out_valid <= 1'b1;
                r_out_sof   <= (r_rd_beat == '0);
                r_out_eof   <= w_rd_last;
                if (w_rd_last) begin
                    r_rd_beat <= '0;
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_rd_beat <= r_rd_beat + 1'b1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_sof   <= 1'b0;
                r_out_eof   <= 1'b0;
            end
            if (w_frame_done) begin
                r_frames_out <= r_frames_out + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready   = w_in_ready;
    assign wr_en      = w_wr_en;
    assign wr_bank    = r_wr_bank;
    assign wr_beat    = w_abort ? '0 : r_wr_beat;
    assign rd_en      = w_rd_en;
    assign rd_bank    = r_rd_bank;
    assign rd_beat    = r_rd_beat;
    assign out_valid  = r_out_valid;
    assign out_sof    = r_out_sof;
    assign out_eof    = r_out_eof;
    assign frame_done = w_frame_done;
    assign sof_err    = r_sof_err;
    assign frames_out = r_frames_out;

endmodule
`default_nettype wire

// File: tb/tb_reorder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reorder_ctrl
//  Description : Directed self-checking bench for reorder_ctrl. Inputs
//                change 1 time unit after the rising edge; outputs are
//                checked mid-cycle and by a negedge stream monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reorder_ctrl;

    localparam int NBEAT  = 32;
    localparam int BEAT_W = 5;
    localparam int FCNT_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_sof;
    logic              in_ready;
    logic              wr_en;
    logic              wr_bank;
    logic [BEAT_W-1:0] wr_beat;
    logic              rd_en;
    logic              rd_bank;
    logic [BEAT_W-1:0] rd_beat;
    logic              out_valid;
    logic              out_ready;
    logic              out_sof;
    logic              out_eof;
    logic              frame_done;
    logic              sof_err;
    logic              err_clr;
    logic [FCNT_W-1:0] frames_out;

    int n_checks = 0;
    int n_pass   = 0;
    int hs_cnt   = 0;
    int fd_cnt   = 0;
    int mon_idx  = 0;
    int hs_base;
    int fd_base;
    int k;
    logic prev_stall = 1'b0;
    logic prev_sof   = 1'b0;
    logic prev_eof   = 1'b0;
    logic [3:0] pat  = 4'b1001;

    reorder_ctrl #(
        .NBEAT (NBEAT),
        .BEAT_W(BEAT_W),
        .FCNT_W(FCNT_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_bank   (wr_bank),
        .wr_beat   (wr_beat),
        .rd_en     (rd_en),
        .rd_bank   (rd_bank),
        .rd_beat   (rd_beat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .frame_done(frame_done),
        .sof_err   (sof_err),
        .err_clr   (err_clr),
        .frames_out(frames_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
        step();
        #2;
        check("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        step();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_wr_en"},      wr_en,      1'b0);
        check({tag, "_rd_en"},      rd_en,      1'b0);
        check({tag, "_out_valid"},  out_valid,  1'b0);
        check({tag, "_out_sof"},    out_sof,    1'b0);
        check({tag, "_out_eof"},    out_eof,    1'b0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
        check({tag, "_sof_err"},    sof_err,    1'b0);
        check({tag, "_frames_out"}, frames_out, 0);
        check({tag, "_wr_bank"},    wr_bank,    1'b0);
        check({tag, "_rd_bank"},    rd_bank,    1'b0);
        check({tag, "_wr_beat"},    wr_beat,    0);
        check({tag, "_rd_beat"},    rd_beat,    0);
    endtask

    // Present one beat, wait (bounded) for acceptance, check write control
    task automatic send_beat(input logic sof, input logic exp_en, input int exp_beat,
                             input logic exp_bank, input string tag);
        int n;
        n = 0;
        in_valid = 1'b1; in_sof = sof;
        #2;
        while (!in_ready && n < 300) begin
            step(); #2; n++;
        end
        check({tag, "_rdy"}, in_ready, 1'b1);
        check({tag, "_wen"}, wr_en, exp_en);
        if (exp_en) begin
            check({tag, "_beat"}, wr_beat, exp_beat);
            check({tag, "_bank"}, wr_bank, exp_bank);
        end
        step();
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic send_frame(input logic exp_bank, input string tag);
        for (int b = 0; b < NBEAT; b++) send_beat(b == 0, 1'b1, b, exp_bank, tag);
    endtask

    task automatic wait_frames(input int n, input string tag);
        int c;
        c = 0;
        while (int'(frames_out) != n && c < 300) begin
            step(); c++;
        end
        check(tag, frames_out, n);
    endtask

    initial begin
        fork
            // Stream monitor: frame flags, stall stability, no read on a held slot
            forever begin
                @(negedge clk);
                if (rst) begin
                    mon_idx = 0; prev_stall = 1'b0;
                end else begin
                    if (prev_stall) begin
                        check("stall_valid", out_valid, 1'b1);
                        check("stall_sof",   out_sof,   prev_sof);
                        check("stall_eof",   out_eof,   prev_eof);
                    end
                    if (out_valid && !out_ready) check("stall_rd_en", rd_en, 1'b0);
                    if (frame_done) fd_cnt++;
                    if (out_valid && out_ready) begin
                        check("hs_sof", out_sof,    mon_idx == 0);
                        check("hs_eof", out_eof,    mon_idx == NBEAT - 1);
                        check("hs_fd",  frame_done, mon_idx == NBEAT - 1);
                        hs_cnt++;
                        mon_idx = (mon_idx + 1) % NBEAT;
                    end
                    prev_stall = out_valid && !out_ready;
                    prev_sof   = out_sof;
                    prev_eof   = out_eof;
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1);
            end
        join_none

        // ---- 1: single frame, out_ready high ----
        do_reset();
        #2;
        check("t1_in_ready", in_ready, 1'b1);
        check_idle("t1_reset");
        step();
        hs_base = hs_cnt; fd_base = fd_cnt;
        send_frame(1'b0, "t1_wr");
        #2;                                   // T+1
        check("t1_rd_en",   rd_en,     1'b1);
        check("t1_rd_beat", rd_beat,   0);
        check("t1_rd_bank", rd_bank,   1'b0);
        check("t1_ov_T1",   out_valid, 1'b0);
        step(); #2;                           // T+2
        check("t1_ov_T2",   out_valid, 1'b1);
        check("t1_sof_T2",  out_sof,   1'b1);
        check("t1_eof_T2",  out_eof,   1'b0);
        repeat (31) step();
        #2;                                   // T+33
        check("t1_ov_T33",  out_valid,  1'b1);
        check("t1_eof_T33", out_eof,    1'b1);
        check("t1_fd_T33",  frame_done, 1'b1);
        step(); #2;                           // T+34
        check("t1_ov_T34",  out_valid,  1'b0);
        check("t1_frames",  frames_out, 1);
        check("t1_hs",      hs_cnt - hs_base, 32);
        check("t1_fd_cnt",  fd_cnt - fd_base, 1);
        step();

        // ---- 2: three frames, downstream stalled, then released ----
        do_reset();
        out_ready = 1'b0;
        hs_base = hs_cnt;
        send_frame(1'b0, "t2_f0");
        send_frame(1'b1, "t2_f1");
        #2;
        check("t2_full_rdy", in_ready, 1'b0);
        check("t2_wr_bank",  wr_bank,  1'b0);
        step(); step(); step();
        #2;
        check("t2_hold_ov",  out_valid, 1'b1);
        check("t2_hold_sof", out_sof,   1'b1);
        check("t2_hold_rb",  rd_beat,   1);
        check("t2_hold_rdy", in_ready,  1'b0);
        step();
        out_ready = 1'b1;
        #2;
        k = 0;
        while (!in_ready && k < 100) begin
            step(); #2; k++;
        end
        check("t2_rdy_lat", k, 31);
        step();
        send_frame(1'b0, "t2_f2");
        wait_frames(3, "t2_frames");
        check("t2_hs",      hs_cnt - hs_base, 96);
        check("t2_rd_bank", rd_bank, 1'b1);
        check("t2_wr_bank_end", wr_bank, 1'b1);
        step();

        // ---- 3: leading beats without SOF are dropped ----
        do_reset();
        for (int i = 0; i < 5; i++) send_beat(1'b0, 1'b0, 0, 1'b0, "t3_drop");
        #2;
        check("t3_hunt_beat", wr_beat, 0);
        check("t3_hunt_rd",   rd_en,   1'b0);
        step();
        send_frame(1'b0, "t3_wr");
        wait_frames(1, "t3_frames");
        step();

        // ---- 4: misaligned SOF, error clear, clear/error collision ----
        do_reset();
        for (int b = 0; b < 10; b++) send_beat(b == 0, 1'b1, b, 1'b0, "t4_pre");
        send_beat(1'b1, 1'b1, 0, 1'b0, "t4_abort");
        #2;
        check("t4_sof_err",  sof_err,  1'b1);
        check("t4_wr_beat",  wr_beat,  1);
        check("t4_no_full",  rd_en,    1'b0);
        check("t4_rdy",      in_ready, 1'b1);
        step();
        for (int b = 1; b < NBEAT; b++) send_beat(1'b0, 1'b1, b, 1'b0, "t4_rest");
        wait_frames(1, "t4_frames");
        check("t4_err_held", sof_err, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        #2;
        check("t4_err_clr", sof_err, 1'b0);
        step();
        for (int b = 0; b < 5; b++) send_beat(b == 0, 1'b1, b, 1'b1, "t4_b1");
        err_clr = 1'b1;
        send_beat(1'b1, 1'b1, 0, 1'b1, "t4_coll");
        err_clr = 1'b0;
        #2;
        check("t4_coll_err", sof_err, 1'b1);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        #2;
        check("t4_clr2", sof_err, 1'b0);
        step();

        // ---- 5: out_ready pattern 1,0,0,1 ----
        do_reset();
        out_ready = 1'b0;
        hs_base = hs_cnt; fd_base = fd_cnt;
        send_frame(1'b0, "t5_wr");
        for (int c = 0; c < 300 && frames_out != 1; c++) begin
            out_ready = pat[c % 4];
            step();
        end
        out_ready = 1'b1;
        repeat (10) step();
        check("t5_frames", frames_out, 1);
        check("t5_hs",     hs_cnt - hs_base, 32);
        check("t5_fd_cnt", fd_cnt - fd_base, 1);

        // ---- 6: reset mid-drain ----
        do_reset();
        send_frame(1'b0, "t6_f0");
        k = 0;
        while (rd_beat != 12 && k < 100) begin
            step(); k++;
        end
        check("t6_reach", rd_beat, 12);
        rst = 1'b1;
        step();
        #2;
        check("t6_rdy", in_ready, 1'b0);
        check_idle("t6_rst");
        rst = 1'b0;
        step();
        send_frame(1'b0, "t6_f1");
        #2;
        check("t6_rd_en",   rd_en,   1'b1);
        check("t6_rd_bank", rd_bank, 1'b0);
        check("t6_rd_beat", rd_beat, 0);
        step();
        wait_frames(1, "t6_frames");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
